// File: rtl/data_memory_ws.sv
// ---------------------------------------------------------------------------
// data_memory_ws
//   MEM-stage data memory for the ARM pipeline. Every access goes through a
//   programmable number of wait states. The pipeline holds a request until a
//   one-cycle ready pulse arrives, and stall keeps the upstream stages frozen
//   until then. Writes honour per-byte lane enables. Accesses that are out of
//   range, misaligned, or that ask for a read and a write together are
//   rejected: they raise fault and leave the memory untouched.
//
// Parameters
//   DATA_W       data word width in bits (multiple of 8)
//   ADDR_W       byte-address width
//   DEPTH        number of DATA_W words
//   BASE_ADDR    byte address of word 0
//   WAIT_CYCLES  extra access cycles, 0..15
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   req_rd   in   read request, held until ready
//   req_wr   in   write request, held until ready
//   addr     in   byte address (ALU result)
//   wdata    in   store data
//   byte_en  in   write byte lanes, bit k covers bits [8k+7:8k]
//   rdata    out  registered read data, valid while ready=1
//   ready    out  one-cycle completion pulse
//   stall    out  request pending and not yet completed (combinational)
//   fault    out  access rejected, valid while ready=1
// ---------------------------------------------------------------------------
module data_memory_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_rd,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                stall,
  output logic                fault
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0]        cnt;
  logic              op_rd;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [LANES-1:0]  be_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;
  logic [IDX_W-1:0]  widx;
  logic              bad;

  // Address decode works on the captured address only, so the inputs may
  // change freely once a request has been accepted. An address below the
  // base wraps to a huge offset; it is still listed explicitly so the
  // rejection does not depend on that wrap.
  always_comb begin
    off  = addr_q - ADDR_W'(BASE_ADDR);
    idx  = off >> 2;
    widx = idx[IDX_W-1:0];
    bad  = (op_rd & op_wr)
         | (addr_q < ADDR_W'(BASE_ADDR))
         | (idx >= ADDR_W'(DEPTH))
         | (addr_q[1:0] != 2'b00);
  end

  // State register. An asynchronous reset aborts any access in flight, so
  // no write lands and no ready pulse is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. RESP always returns to IDLE, so a request that is
  // still held there is only picked up again one cycle later.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_rd | req_wr) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0)     next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ready = (state == RESP);
  assign stall = (req_rd | req_wr) & ~ready;

  // Request capture, wait-state countdown and the memory access itself.
  // Reset also loads mem[i]=i, which gives every word a known value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      op_rd   <= 1'b0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata   <= '0;
      fault   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(i);
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_rd | req_wr) begin
            op_rd   <= req_rd;
            op_wr   <= req_wr;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= byte_en;
            cnt     <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            fault <= bad;
            if (bad) begin
              rdata <= '0;
            end else if (op_wr) begin
              rdata <= '0;
              for (int k = 0; k < LANES; k++) begin
                if (be_q[k]) begin
                  mem[widx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
              end
            end else begin
              rdata <= mem[widx];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ws
//   Directed bench for data_memory_ws. The main instance uses two wait
//   states. A second instance with no wait states covers back-to-back
//   throughput. All expected values are constants worked out by hand from
//   the reset image mem[i]=i.
// ---------------------------------------------------------------------------
module tb_data_memory_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic [31:0] rdata;
  logic        ready;
  logic        stall;
  logic        fault;

  logic        req_rd0;
  logic        req_wr0;
  logic [31:0] addr0;
  logic [31:0] rdata0;
  logic        ready0;
  logic        stall0;
  logic        fault0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_ws #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
    .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .ready(ready),
    .stall(stall), .fault(fault)
  );

  data_memory_ws #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst(rst), .req_rd(req_rd0), .req_wr(req_wr0), .addr(addr0),
    .wdata(wdata), .byte_en(byte_en), .rdata(rdata0), .ready(ready0),
    .stall(stall0), .fault(fault0)
  );

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One complete transaction on the WAIT_CYCLES=2 instance. It is entered
  // just after a rising edge with the DUT idle, and it leaves the DUT idle
  // again just after a rising edge. Ready is expected in cycle 4, and stall
  // must stay high until then.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be,
                               input logic [31:0] exp_rdata,
                               input logic exp_fault, input string tag);
    int n;
    req_rd  = rd;
    req_wr  = wr;
    addr    = a;
    wdata   = d;
    byte_en = be;
    #1;
    checkOutput({tag, "_stall_c0"}, 64'(stall), 64'd1);
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
      if (ready !== 1'b1) checkOutput({tag, "_stall_wait"}, 64'(stall), 64'd1);
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'd4);
    checkOutput({tag, "_rdata"}, 64'(rdata), 64'(exp_rdata));
    checkOutput({tag, "_fault"}, 64'(fault), 64'(exp_fault));
    checkOutput({tag, "_stall_resp"}, 64'(stall), 64'd0);
    req_rd = 1'b0;
    req_wr = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_ready_drop"}, 64'(ready), 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    req_rd  = 1'b0;
    req_wr  = 1'b0;
    addr    = '0;
    wdata   = '0;
    byte_en = '0;
    req_rd0 = 1'b0;
    req_wr0 = 1'b0;
    addr0   = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 64'(ready), 64'd0);
    checkOutput("rst_fault", 64'(fault), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: read word 5
    applyStimulus(1'b1, 1'b0, 32'd1044, 32'd0, 4'hF, 32'd5, 1'b0, "t1_rd5");

    // T2: partial-lane write, then read back
    applyStimulus(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'b0011, 32'd0, 1'b0, "t2_wr");
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, 4'h0, 32'h0000BEEF, 1'b0, "t2_rd");
    applyStimulus(1'b0, 1'b1, 32'd1036, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0, "t2_wr_nobe");
    applyStimulus(1'b1, 1'b0, 32'd1036, 32'd0, 4'h0, 32'd3, 1'b0, "t2_rd_nobe");

    // T3: range and alignment faults, including a rejected write
    applyStimulus(1'b1, 1'b0, 32'd1020, 32'd0, 4'h0, 32'd0, 1'b1, "t3_below");
    applyStimulus(1'b1, 1'b0, 32'd1280, 32'd0, 4'h0, 32'd0, 1'b1, "t3_above");
    applyStimulus(1'b1, 1'b0, 32'd1026, 32'd0, 4'h0, 32'd0, 1'b1, "t3_misalign");
    applyStimulus(1'b0, 1'b1, 32'd1030, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, "t3_wr_misalign");
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0, 4'h0, 32'd1, 1'b0, "t3_unchanged");
    applyStimulus(1'b1, 1'b0, 32'd1276, 32'd0, 4'h0, 32'd63, 1'b0, "t3_last_word");

    // T4: read and write requested together
    applyStimulus(1'b1, 1'b1, 32'd1028, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, "t4_both");
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'd0, 4'h0, 32'd1, 1'b0, "t4_rd");

    // T5: reset during ACCESS aborts the write and reloads the memory
    req_wr  = 1'b1;
    addr    = 32'd1040;
    wdata   = 32'h55;
    byte_en = 4'hF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5_ready_in_rst", 64'(ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_ready_held_rst", 64'(ready), 64'd0);
    checkOutput("t5_rdata_cleared", 64'(rdata), 64'd0);
    req_wr = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_stall_idle", 64'(stall), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'd1040, 32'd0, 4'h0, 32'd4, 1'b0, "t5_rd");
    applyStimulus(1'b1, 1'b0, 32'd1032, 32'd0, 4'h0, 32'd2, 1'b0, "t5_reinit");

    // T6: zero wait states, read held continuously -> ready in cycles 2, 5, 8
    req_rd0 = 1'b1;
    addr0   = 32'd1052;
    for (int k = 0; k < 9; k++) begin
      #1;
      checkOutput($sformatf("t6_ready_c%0d", k), 64'(ready0), 64'(k % 3 == 2));
      checkOutput($sformatf("t6_stall_c%0d", k), 64'(stall0), 64'(k % 3 != 2));
      if (k % 3 == 2) begin
        checkOutput($sformatf("t6_rdata_c%0d", k), 64'(rdata0), 64'd7);
        checkOutput($sformatf("t6_fault_c%0d", k), 64'(fault0), 64'd0);
      end
      @(posedge clk);
    end
    req_rd0 = 1'b0;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
